// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO with valid/ready handshakes on both sides.
// The enqueue and dequeue counters carry one extra wrap bit. When they are equal,
// the FIFO is empty. When the pointers match and the wrap bits differ, it is full.
// A state-load port (init) and mirror outputs let a bench place the FIFO in any
// state and then observe the state it moves to next.
module sync_fifo #(
  parameter  int N_ENTRIES   = 4,
  parameter  int ENTRY_WIDTH = 4,
  localparam int PTR_WIDTH   = $clog2(N_ENTRIES),
  localparam int CTR_WIDTH   = PTR_WIDTH + 1
) (
  input  logic                             clk,
  input  logic                             rst_aL,
  input  logic                             enq_valid,
  input  logic [ENTRY_WIDTH-1:0]           enq_data,
  output logic                             enq_ready,
  input  logic                             deq_ready,
  output logic                             deq_valid,
  output logic [ENTRY_WIDTH-1:0]           deq_data,
  input  logic                             init,
  input  logic [N_ENTRIES*ENTRY_WIDTH-1:0] init_entry_reg_state,
  input  logic [CTR_WIDTH-1:0]             init_enq_up_counter_state,
  input  logic [CTR_WIDTH-1:0]             init_deq_up_counter_state,
  output logic [N_ENTRIES*ENTRY_WIDTH-1:0] current_entry_reg_state,
  output logic [CTR_WIDTH-1:0]             current_enq_up_counter_state,
  output logic [CTR_WIDTH-1:0]             current_deq_up_counter_state
);

  logic [N_ENTRIES*ENTRY_WIDTH-1:0] entry_q, entry_d, entry_s;
  logic [CTR_WIDTH-1:0]             enq_ctr_q, enq_ctr_d, enq_ctr_s;
  logic [CTR_WIDTH-1:0]             deq_ctr_q, deq_ctr_d, deq_ctr_s;
  logic [PTR_WIDTH-1:0]             enq_ptr, deq_ptr;
  logic                             empty, full, enq_fire, deq_fire;

  // Effective state. While init is high, the load values show through at once
  // with no clock edge. The flops capture them when init rises and on every edge
  // while init stays high.
  always_comb begin
    entry_s   = init ? init_entry_reg_state      : entry_q;
    enq_ctr_s = init ? init_enq_up_counter_state : enq_ctr_q;
    deq_ctr_s = init ? init_deq_up_counter_state : deq_ctr_q;
  end

  // Status flags and the handshakes. A full FIFO refuses enqueue even when a
  // dequeue fires in the same cycle.
  always_comb begin
    enq_ptr   = enq_ctr_s[PTR_WIDTH-1:0];
    deq_ptr   = deq_ctr_s[PTR_WIDTH-1:0];
    empty     = (enq_ctr_s == deq_ctr_s);
    full      = (enq_ptr == deq_ptr) && (enq_ctr_s[CTR_WIDTH-1] != deq_ctr_s[CTR_WIDTH-1]);
    enq_ready = !full;
    deq_valid = !empty;
    enq_fire  = enq_valid && enq_ready;
    deq_fire  = deq_valid && deq_ready;
  end

  // Head entry. It is driven even when the FIFO is empty, so stale data shows.
  always_comb begin
    deq_data = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (deq_ptr == PTR_WIDTH'(i)) deq_data = entry_s[i*ENTRY_WIDTH +: ENTRY_WIDTH];
    end
  end

  // Next state. Only the addressed entry is written. A dequeue only advances the
  // read counter and does not clear the entry.
  always_comb begin
    entry_d   = entry_s;
    enq_ctr_d = enq_ctr_s;
    deq_ctr_d = deq_ctr_s;
    if (enq_fire) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (enq_ptr == PTR_WIDTH'(i)) entry_d[i*ENTRY_WIDTH +: ENTRY_WIDTH] = enq_data;
      end
      enq_ctr_d = enq_ctr_s + CTR_WIDTH'(1);
    end
    if (deq_fire) deq_ctr_d = deq_ctr_s + CTR_WIDTH'(1);
  end

  // State registers. Load takes priority over the synchronous reset, and the
  // reset takes priority over any handshake.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      entry_q   <= init_entry_reg_state;
      enq_ctr_q <= init_enq_up_counter_state;
      deq_ctr_q <= init_deq_up_counter_state;
    end else if (!rst_aL) begin
      entry_q   <= '0;
      enq_ctr_q <= '0;
      deq_ctr_q <= '0;
    end else begin
      entry_q   <= entry_d;
      enq_ctr_q <= enq_ctr_d;
      deq_ctr_q <= deq_ctr_d;
    end
  end

  // Observation ports mirror the effective state.
  always_comb begin
    current_entry_reg_state      = entry_s;
    current_enq_up_counter_state = enq_ctr_s;
    current_deq_up_counter_state = deq_ctr_s;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with the default parameters (4 entries x 4 bits).
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        rst_aL = 1'b0;
  logic        enq_valid = 1'b0;
  logic [3:0]  enq_data = '0;
  logic        enq_ready;
  logic        deq_ready = 1'b0;
  logic        deq_valid;
  logic [3:0]  deq_data;
  logic        init = 1'b0;
  logic [15:0] init_entry = '0;
  logic [2:0]  init_enq = '0;
  logic [2:0]  init_deq = '0;
  logic [15:0] cur_entry;
  logic [2:0]  cur_enq;
  logic [2:0]  cur_deq;

  int checks = 0;
  int errors = 0;

  sync_fifo #(.N_ENTRIES(4), .ENTRY_WIDTH(4)) dut (
    .clk                          (clk),
    .rst_aL                       (rst_aL),
    .enq_valid                    (enq_valid),
    .enq_data                     (enq_data),
    .enq_ready                    (enq_ready),
    .deq_ready                    (deq_ready),
    .deq_valid                    (deq_valid),
    .deq_data                     (deq_data),
    .init                         (init),
    .init_entry_reg_state         (init_entry),
    .init_enq_up_counter_state    (init_enq),
    .init_deq_up_counter_state    (init_deq),
    .current_entry_reg_state      (cur_entry),
    .current_enq_up_counter_state (cur_enq),
    .current_deq_up_counter_state (cur_deq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ent;
    logic [2:0]  enq;
    logic [2:0]  deq;
    logic        rst_b;
    logic        ev;
    logic [3:0]  ed;
    logic        dr;
    logic        er;
    logic        dv;
    logic [3:0]  dd;
    logic [15:0] n_ent;
    logic [2:0]  n_enq;
    logic [2:0]  n_deq;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //          ent      enq     deq     rst  ev    ed     dr    er    dv    dd     n_ent    n_enq   n_deq
    vecs[0] = '{16'h0000, 3'b000, 3'b000, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0001, 3'b001, 3'b000};
    vecs[1] = '{16'h000f, 3'b001, 3'b000, 1'b1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 4'hf, 16'h002f, 3'b010, 3'b000};
    vecs[2] = '{16'h000f, 3'b010, 3'b000, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 4'hf, 16'h030f, 3'b011, 3'b000};
    vecs[3] = '{16'h0e0f, 3'b011, 3'b000, 1'b1, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 4'hf, 16'h4e0f, 3'b100, 3'b000};
    // full: enqueue refused even though a dequeue fires
    vecs[4] = '{16'h4e0f, 3'b100, 3'b000, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 4'hf, 16'h4e0f, 3'b100, 3'b001};
    // both fire, enq counter wraps 111 -> 000
    vecs[5] = '{16'h1234, 3'b111, 3'b110, 1'b1, 1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 4'h2, 16'h9234, 3'b000, 3'b111};
    // reset overrides both fires
    vecs[6] = '{16'habcd, 3'b001, 3'b000, 1'b0, 1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 4'hd, 16'h0000, 3'b000, 3'b000};
    // empty: no dequeue, stale head still visible
    vecs[7] = '{16'h5555, 3'b010, 3'b010, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h5, 16'h5555, 3'b010, 3'b010};
    // full with wrap bits differing at pointer 2, no dequeue
    vecs[8] = '{16'h1234, 3'b110, 3'b010, 1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 4'h2, 16'h1234, 3'b110, 3'b010};

    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_entries", 32'(cur_entry), 32'h0);
    check("reset_enq_ctr", 32'(cur_enq), 32'h0);
    check("reset_deq_ctr", 32'(cur_deq), 32'h0);
    check("reset_enq_ready", 32'(enq_ready), 32'h1);
    check("reset_deq_valid", 32'(deq_valid), 32'h0);
    check("reset_deq_data", 32'(deq_data), 32'h0);
    rst_aL = 1'b1;

    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      init_entry = vecs[v].ent;
      init_enq   = vecs[v].enq;
      init_deq   = vecs[v].deq;
      init       = 1'b1;
      #1;
      init       = 1'b0;
      rst_aL     = vecs[v].rst_b;
      enq_valid  = vecs[v].ev;
      enq_data   = vecs[v].ed;
      deq_ready  = vecs[v].dr;
      #1;
      check($sformatf("v%0d_enq_ready", v), 32'(enq_ready), 32'(vecs[v].er));
      check($sformatf("v%0d_deq_valid", v), 32'(deq_valid), 32'(vecs[v].dv));
      check($sformatf("v%0d_deq_data", v), 32'(deq_data), 32'(vecs[v].dd));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_next_entries", v), 32'(cur_entry), 32'(vecs[v].n_ent));
      check($sformatf("v%0d_next_enq_ctr", v), 32'(cur_enq), 32'(vecs[v].n_enq));
      check($sformatf("v%0d_next_deq_ctr", v), 32'(cur_deq), 32'(vecs[v].n_deq));
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      rst_aL    = 1'b1;
    end

    // reset mid-operation after the wrap vector's state
    @(negedge clk);
    init_entry = 16'h9234; init_enq = 3'b000; init_deq = 3'b111;
    init = 1'b1; #1; init = 1'b0;
    rst_aL = 1'b0; enq_valid = 1'b1; enq_data = 4'h6;
    @(posedge clk); #1;
    check("midreset_entries", 32'(cur_entry), 32'h0);
    check("midreset_ctrs", 32'({cur_enq, cur_deq}), 32'h0);
    check("midreset_deq_valid", 32'(deq_valid), 32'h0);
    rst_aL = 1'b1; enq_valid = 1'b0;

    // one-cycle latency, no bypass into an empty FIFO
    @(negedge clk);
    enq_valid = 1'b1; enq_data = 4'ha;
    #1;
    check("lat_pre_deq_valid", 32'(deq_valid), 32'h0);
    check("lat_pre_deq_data", 32'(deq_data), 32'h0);
    @(posedge clk); #1;
    enq_valid = 1'b0;
    check("lat_post_deq_valid", 32'(deq_valid), 32'h1);
    check("lat_post_deq_data", 32'(deq_data), 32'ha);

    // init acts without a clock edge, beats reset, and persists after release
    @(negedge clk);
    init_entry = 16'h7777; init_enq = 3'b011; init_deq = 3'b001;
    rst_aL = 1'b0;
    init = 1'b1;
    #1;
    check("init_async_enq_ctr", 32'(cur_enq), 32'h3);
    check("init_async_deq_data", 32'(deq_data), 32'h7);
    @(posedge clk); #1;
    check("init_over_reset_entries", 32'(cur_entry), 32'h7777);
    @(negedge clk);
    init = 1'b0;
    #1;
    check("init_held_deq_ctr", 32'(cur_deq), 32'h1);
    check("init_held_entries", 32'(cur_entry), 32'h7777);
    @(posedge clk); #1;
    check("reset_after_init", 32'({cur_entry, cur_enq, cur_deq}), 32'h0);
    rst_aL = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
